// File: rtl/enabler_seq_pkg.sv
// Shared encodings for the sequential state-decode enabler: controller main/sub-state
// values and the per-channel enable FSM states.
package enabler_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WPR  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    localparam logic [2:0] SL_A = 3'd0;
    localparam logic [2:0] SL_B = 3'd1;
    localparam logic [2:0] SL_C = 3'd2;
    localparam logic [2:0] SL_D = 3'd3;
    localparam logic [2:0] SL_E = 3'd4;
    localparam logic [2:0] SL_F = 3'd5;
    localparam logic [2:0] SL_G = 3'd6;
    localparam logic [2:0] SL_H = 3'd7;

    typedef enum logic [2:0] {
        EN_IDLE = 3'd0,
        EN_QUAL = 3'd1,
        EN_ON   = 3'd2,
        EN_HOLD = 3'd3,
        EN_DONE = 3'd4
    } en_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/enabler_chan.sv
// One enable channel: qualifies a match over QUAL_CYC extra cycles, then drives a
// level enable (with optional hold-off) or a single-cycle pulse.
module enabler_chan
    import enabler_seq_pkg::*;
#(
    parameter int QUAL_CYC   = 0,
    parameter int HOLD_CYC   = 0,
    parameter int PULSE_MODE = 0,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cond,
    output logic en,
    output logic en_rise,
    output logic en_next
);

    localparam logic [CNT_W-1:0] QUAL_CNT = CNT_W'(QUAL_CYC);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((1 << CNT_W) <= max_int(QUAL_CYC, HOLD_CYC)) begin : g_cnt_w_check
        $error("enabler_chan: CNT_W too narrow for QUAL_CYC/HOLD_CYC");
    end

    en_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             en_rise_q, en_rise_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EN_IDLE;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            en_rise_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            en_rise_q <= en_rise_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EN_IDLE: begin
                if (cond) begin
                    if (QUAL_CYC == 0) begin
                        state_d = EN_ON;
                    end else begin
                        state_d = EN_QUAL;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            EN_QUAL: begin
                if (!cond) begin
                    state_d = EN_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == QUAL_CNT) begin
                    state_d = EN_ON;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EN_ON: begin
                if (PULSE_MODE != 0) begin
                    state_d = EN_DONE;
                end else if (!cond) begin
                    if (HOLD_CYC == 0) begin
                        state_d = EN_IDLE;
                    end else begin
                        state_d = EN_HOLD;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            // A returning match resumes ON directly; en never drops so no rise pulse.
            EN_HOLD: begin
                if (cond) begin
                    state_d = EN_ON;
                end else if (cnt_q == HOLD_CNT) begin
                    state_d = EN_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EN_DONE: begin
                if (!cond) begin
                    state_d = EN_IDLE;
                end
            end
            default: begin
                state_d = EN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_d      = (state_d == EN_ON) || (state_d == EN_HOLD);
        en_rise_d = en_d && !en_q;
    end

    assign en      = en_q;
    assign en_rise = en_rise_q;
    assign en_next = en_d;

endmodule

// File: rtl/enabler_seq.sv
// Registered state-decode enabler: decodes ST/ST_L into per-channel match terms and
// runs an independent qualify/hold FSM for each of NCH enable outputs.
module enabler_seq
    import enabler_seq_pkg::*;
#(
    parameter int                           NCH        = 2,
    parameter int                           ST_W       = 2,
    parameter int                           STL_W      = 3,
    parameter logic [ST_W-1:0]              ST_MATCH   = S_WPR,
    parameter logic [NCH*(1<<STL_W)-1:0]    SL_MASK    = {NCH{8'b0000_0011}},
    parameter int                           QUAL_CYC   = 0,
    parameter int                           HOLD_CYC   = 0,
    parameter int                           PULSE_MODE = 0,
    parameter int                           CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ST_W-1:0]  ST,
    input  logic [STL_W-1:0] ST_L,
    output logic [NCH-1:0]   en,
    output logic [NCH-1:0]   en_rise,
    output logic             any_en
);

    localparam int NSL = 1 << STL_W;

    logic           st_match;
    logic [NCH-1:0] cond;
    logic [NCH-1:0] en_next;
    logic           any_en_q, any_en_d;

    assign st_match = (ST == ST_MATCH);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic [NSL-1:0] lane_mask;

        assign lane_mask = SL_MASK[g*NSL +: NSL];
        assign cond[g]   = st_match && lane_mask[ST_L];

        enabler_chan #(
            .QUAL_CYC  (QUAL_CYC),
            .HOLD_CYC  (HOLD_CYC),
            .PULSE_MODE(PULSE_MODE),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .cond   (cond[g]),
            .en     (en[g]),
            .en_rise(en_rise[g]),
            .en_next(en_next[g])
        );
    end

    // Fed from next-state enables so any_en lines up with the channel en registers.
    always_comb begin
        any_en_d = |en_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_en_q <= 1'b0;
        end else begin
            any_en_q <= any_en_d;
        end
    end

    assign any_en = any_en_q;

endmodule

// File: tb/tb_enabler_seq.sv
// Directed bench for enabler_seq: three instances (qualify/hold level, immediate level,
// pulse) share one stimulus stream; each task checks the instance it exercises.
module tb_enabler_seq;
    import enabler_seq_pkg::*;

    localparam logic [15:0] MASK = {8'b0000_0010, 8'b0000_0011};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] st  = S_IDLE;
    logic [2:0] st_l = SL_A;

    logic [1:0] en_a, rise_a, en_b, rise_b, en_c, rise_c;
    logic       any_a, any_b, any_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    enabler_seq #(.NCH(2), .ST_W(2), .STL_W(3), .ST_MATCH(S_WPR), .SL_MASK(MASK),
                  .QUAL_CYC(2), .HOLD_CYC(3), .PULSE_MODE(0), .CNT_W(4))
        dut_a (.clk(clk), .rst(rst), .ST(st), .ST_L(st_l),
               .en(en_a), .en_rise(rise_a), .any_en(any_a));

    enabler_seq #(.NCH(2), .ST_W(2), .STL_W(3), .ST_MATCH(S_WPR), .SL_MASK(MASK),
                  .QUAL_CYC(0), .HOLD_CYC(0), .PULSE_MODE(0), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst), .ST(st), .ST_L(st_l),
               .en(en_b), .en_rise(rise_b), .any_en(any_b));

    enabler_seq #(.NCH(2), .ST_W(2), .STL_W(3), .ST_MATCH(S_WPR), .SL_MASK(MASK),
                  .QUAL_CYC(0), .HOLD_CYC(0), .PULSE_MODE(1), .CNT_W(4))
        dut_c (.clk(clk), .rst(rst), .ST(st), .ST_L(st_l),
               .en(en_c), .en_rise(rise_c), .any_en(any_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        st  = S_IDLE;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        st   = S_WPR;
        st_l = SL_A;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({en_a, rise_a, any_a, en_b, rise_b, any_b, en_c, rise_c, any_c} !== 15'b0) begin
                n_bad++;
                $display("[TB] FAIL reset_hold cyc%0d: got %b want %b", i,
                         {en_a, rise_a, any_a, en_b, rise_b, any_b, en_c, rise_c, any_c}, 15'b0);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({en_a, rise_a, any_a} !== 5'b00000 || {en_b, rise_b, any_b} !== 5'b01011) begin
            n_bad++;
            $display("[TB] FAIL reset_rel1: got a=%b b=%b want a=00000 b=01011",
                     {en_a, rise_a, any_a}, {en_b, rise_b, any_b});
        end
        tick();
        n_cmp++;
        if ({en_a, rise_a, any_a} !== 5'b00000) begin
            n_bad++;
            $display("[TB] FAIL reset_rel2: got %b want 00000", {en_a, rise_a, any_a});
        end
        tick();
        n_cmp++;
        if ({en_a, rise_a, any_a} !== 5'b01011) begin
            n_bad++;
            $display("[TB] FAIL reset_rel3: got %b want 01011", {en_a, rise_a, any_a});
        end
    endtask

    task automatic test_qualify();
        logic [4:0] exp_a [5];
        exp_a = '{5'b00000, 5'b00000, 5'b01011, 5'b01001, 5'b01001};
        do_reset();
        st   = S_WPR;
        st_l = SL_A;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({en_a, rise_a, any_a} !== exp_a[i]) begin
                n_bad++;
                $display("[TB] FAIL qualify_c%0d: got %b want %b", i + 1, {en_a, rise_a, any_a}, exp_a[i]);
            end
        end
        // Both channels armed by SL_B qualify together.
        do_reset();
        st   = S_WPR;
        st_l = SL_B;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({en_a, rise_a, any_a} !== 5'b11111) begin
            n_bad++;
            $display("[TB] FAIL qualify_both: got %b want 11111", {en_a, rise_a, any_a});
        end
    endtask

    task automatic test_glitch();
        logic [4:0] exp_a [6];
        logic [1:0] st_seq [6];
        exp_a  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01011};
        st_seq = '{S_WPR, S_WPR, S_IDLE, S_WPR, S_WPR, S_WPR};
        do_reset();
        st_l = SL_A;
        for (int i = 0; i < 6; i++) begin
            st = st_seq[i];
            tick();
            n_cmp++;
            if ({en_a, rise_a, any_a} !== exp_a[i]) begin
                n_bad++;
                $display("[TB] FAIL glitch_c%0d: got %b want %b", i + 1, {en_a, rise_a, any_a}, exp_a[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [4:0] exp_a [4];
        exp_a = '{5'b01001, 5'b01001, 5'b01001, 5'b00000};
        do_reset();
        st   = S_WPR;
        st_l = SL_A;
        tick();
        tick();
        tick();
        st = S_IDLE;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({en_a, rise_a, any_a} !== exp_a[i]) begin
                n_bad++;
                $display("[TB] FAIL hold_t+%0d: got %b want %b", i + 1, {en_a, rise_a, any_a}, exp_a[i]);
            end
        end
        st = S_WPR;
        tick();
        tick();
        tick();
        st = S_IDLE;
        tick();
        tick();
        st = S_WPR;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({en_a, rise_a, any_a} !== 5'b01001) begin
                n_bad++;
                $display("[TB] FAIL hold_restore%0d: got %b want 01001", i, {en_a, rise_a, any_a});
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        st   = S_WPR;
        st_l = SL_A;
        tick();
        tick();
        tick();
        st = S_IDLE;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({en_a, rise_a, any_a} !== 5'b00000) begin
            n_bad++;
            $display("[TB] FAIL midhold_rst: got %b want 00000", {en_a, rise_a, any_a});
        end
        rst = 1'b0;
        st  = S_WPR;
        tick();
        tick();
        n_cmp++;
        if ({en_a, rise_a, any_a} !== 5'b00000) begin
            n_bad++;
            $display("[TB] FAIL midhold_requal2: got %b want 00000", {en_a, rise_a, any_a});
        end
        tick();
        n_cmp++;
        if ({en_a, rise_a, any_a} !== 5'b01011) begin
            n_bad++;
            $display("[TB] FAIL midhold_requal3: got %b want 01011", {en_a, rise_a, any_a});
        end
    endtask

    task automatic test_channel_switch();
        do_reset();
        st   = S_WPR;
        st_l = SL_A;
        tick();
        n_cmp++;
        if ({en_b, rise_b, any_b} !== 5'b01011) begin
            n_bad++;
            $display("[TB] FAIL switch_on0: got %b want 01011", {en_b, rise_b, any_b});
        end
        st_l = SL_B;
        tick();
        n_cmp++;
        if ({en_b, rise_b, any_b} !== 5'b11101) begin
            n_bad++;
            $display("[TB] FAIL switch_on1: got %b want 11101", {en_b, rise_b, any_b});
        end
        st_l = SL_A;
        tick();
        n_cmp++;
        if ({en_b, rise_b, any_b} !== 5'b01001) begin
            n_bad++;
            $display("[TB] FAIL switch_off1: got %b want 01001", {en_b, rise_b, any_b});
        end
        st = S_RD;
        tick();
        n_cmp++;
        if ({en_b, rise_b, any_b} !== 5'b00000) begin
            n_bad++;
            $display("[TB] FAIL switch_alloff: got %b want 00000", {en_b, rise_b, any_b});
        end
    endtask

    task automatic test_pulse();
        do_reset();
        st   = S_WPR;
        st_l = SL_A;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({en_c, rise_c, any_c} !== ((i == 0) ? 5'b01011 : 5'b00000)) begin
                n_bad++;
                $display("[TB] FAIL pulse_c%0d: got %b want %b", i + 1, {en_c, rise_c, any_c},
                         (i == 0) ? 5'b01011 : 5'b00000);
            end
        end
        st = S_IDLE;
        tick();
        st = S_WPR;
        tick();
        n_cmp++;
        if ({en_c, rise_c, any_c} !== 5'b01011) begin
            n_bad++;
            $display("[TB] FAIL pulse_rearm: got %b want 01011", {en_c, rise_c, any_c});
        end
        tick();
        n_cmp++;
        if ({en_c, rise_c, any_c} !== 5'b00000) begin
            n_bad++;
            $display("[TB] FAIL pulse_rearm_end: got %b want 00000", {en_c, rise_c, any_c});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({en_c, rise_c, any_c} !== 5'b01011) begin
            n_bad++;
            $display("[TB] FAIL pulse_after_rst: got %b want 01011", {en_c, rise_c, any_c});
        end
    endtask

    initial begin
        test_reset();
        test_qualify();
        test_glitch();
        test_hold();
        test_mid_reset();
        test_channel_switch();
        test_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
